// File: rtl/i2c_responder_pkg.sv
// i2c_responder_pkg
//   Shared types and widths for the I2C responder (target) block.
//   - i2c_state_e : responder FSM states
//   - I2C_ADDR_W  : width of a 7-bit I2C target address
//   - I2C_BYTE_W  : width of one I2C data byte
package i2c_responder_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_BYTE_W = 8;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      ADDR     = 3'd1,
      ADDR_ACK = 3'd2,
      RX_BYTE  = 3'd3,
      RX_ACK   = 3'd4,
      TX_BYTE  = 3'd5,
      TX_ACK   = 3'd6,
      IGNORE   = 3'd7
   } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync
//   Brings the asynchronous SCL/SDA bus lines into the clk_i domain and
//   derives single-cycle bus events from them.  Every event output is a
//   register, so an edge on a pin shows up SYNC_STAGES+1 cycles later.
// Ports
//   clk_i      : system clock
//   rst_i      : synchronous reset, active low
//   scl_i      : raw SCL from the bus
//   sda_i      : raw SDA from the bus
//   sda_lvl_o  : synchronized SDA, aligned with the event pulses
//   scl_rise_o : 1-cycle pulse on SCL rising edge
//   scl_fall_o : 1-cycle pulse on SCL falling edge
//   start_o    : 1-cycle pulse, SDA fell while SCL high
//   stop_o     : 1-cycle pulse, SDA rose while SCL high
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_lvl_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   logic [SYNC_STAGES-1:0] scl_sync_r;
   logic [SYNC_STAGES-1:0] sda_sync_r;
   logic                   scl_s;
   logic                   sda_s;
   logic                   scl_d_r;
   logic                   sda_d_r;
   logic                   scl_rise_r;
   logic                   scl_fall_r;
   logic                   start_r;
   logic                   stop_r;

   assign scl_s = scl_sync_r[SYNC_STAGES-1];
   assign sda_s = sda_sync_r[SYNC_STAGES-1];

   // Synchronizer chains, one-cycle history and registered event detection.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         // Preset to the idle bus level so leaving reset creates no false edge.
         scl_sync_r <= {SYNC_STAGES{1'b1}};
         sda_sync_r <= {SYNC_STAGES{1'b1}};
         scl_d_r    <= 1'b1;
         sda_d_r    <= 1'b1;
         scl_rise_r <= 1'b0;
         scl_fall_r <= 1'b0;
         start_r    <= 1'b0;
         stop_r     <= 1'b0;
      end else begin
         scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_i};
         sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_i};
         scl_d_r    <= scl_s;
         sda_d_r    <= sda_s;
         scl_rise_r <= scl_s & ~scl_d_r;
         scl_fall_r <= ~scl_s & scl_d_r;
         // SCL must be high on both samples so an SCL edge is never taken as START/STOP.
         start_r    <= scl_s & scl_d_r & sda_d_r & ~sda_s;
         stop_r     <= scl_s & scl_d_r & ~sda_d_r & sda_s;
      end
   end

   assign sda_lvl_o  = sda_d_r;
   assign scl_rise_o = scl_rise_r;
   assign scl_fall_o = scl_fall_r;
   assign start_o    = start_r;
   assign stop_o     = stop_r;

endmodule

// File: rtl/i2c_responder.sv
// i2c_responder
//   I2C target on a single bus.  Detects START/STOP, matches a 7-bit address,
//   ACKs it, then either delivers written bytes on rx_* or fetches read bytes
//   from tx_*.  SDA is driven open-drain only; SCL is never stretched.
// Ports
//   clk_i        : system clock
//   rst_i        : synchronous reset, active low
//   scl_i/sda_i  : raw bus lines (asynchronous)
//   sda_o        : open-drain drive, 0 = pull low, 1 = release
//   slave_addr_i : own address, sampled at the end of the address byte
//   rx_data_o    : last byte received in a write transfer
//   rx_valid_o   : 1-cycle pulse, rx_data_o updated
//   tx_data_i    : next byte for a read transfer
//   tx_valid_i   : tx_data_i available
//   tx_ready_o   : 1-cycle pulse, tx_data_i consumed
//   start_o      : 1-cycle pulse on START / repeated START
//   stop_o       : 1-cycle pulse on STOP
//   rw_o         : R/W bit of the current matched transfer (1 = read)
//   busy_o       : high from matched address ACK until STOP/START
module i2c_responder
   import i2c_responder_pkg::*;
#(
   parameter int                    SYNC_STAGES = 2,
   parameter int                    HOLD_CYCLES = 4,
   parameter logic [I2C_BYTE_W-1:0] IDLE_BYTE   = 8'hFF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  scl_i,
   input  logic                  sda_i,
   output logic                  sda_o,
   input  logic [I2C_ADDR_W-1:0] slave_addr_i,
   output logic [I2C_BYTE_W-1:0] rx_data_o,
   output logic                  rx_valid_o,
   input  logic [I2C_BYTE_W-1:0] tx_data_i,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   output logic                  start_o,
   output logic                  stop_o,
   output logic                  rw_o,
   output logic                  busy_o
);

   localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

   logic                  sda_lvl_s;
   logic                  scl_rise_s;
   logic                  scl_fall_s;
   logic                  start_s;
   logic                  stop_s;

   i2c_state_e            state_r,     state_nxt;
   logic [3:0]            bit_cnt_r,   bit_cnt_nxt;
   logic [I2C_BYTE_W-2:0] shift_r,     shift_nxt;
   logic [I2C_BYTE_W-1:0] tx_shift_r,  tx_shift_nxt;
   logic [HOLD_W-1:0]     hold_cnt_r,  hold_cnt_nxt;
   logic                  ack_phase_r, ack_phase_nxt;
   logic                  sda_r,       sda_nxt;
   logic [I2C_BYTE_W-1:0] rx_data_r,   rx_data_nxt;
   logic                  rx_valid_r,  rx_valid_nxt;
   logic                  tx_ready_r,  tx_ready_nxt;
   logic                  rw_r,        rw_nxt;
   logic                  busy_r,      busy_nxt;
   logic                  load_tx_s;
   logic                  hold_done_s;
   logic [I2C_BYTE_W-1:0] byte_in_s;

   i2c_line_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_line_sync (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .scl_i      (scl_i),
      .sda_i      (sda_i),
      .sda_lvl_o  (sda_lvl_s),
      .scl_rise_o (scl_rise_s),
      .scl_fall_o (scl_fall_s),
      .start_o    (start_s),
      .stop_o     (stop_s)
   );

   // Byte as it will look once the bit on SDA at this SCL rise is shifted in.
   assign byte_in_s   = {shift_r, sda_lvl_s};
   // SDA may change only in the cycle the post-fall hold delay expires.
   assign hold_done_s = (hold_cnt_r == HOLD_W'(1));

   // Next-state, datapath and output decode.
   always_comb begin
      state_nxt     = state_r;
      bit_cnt_nxt   = bit_cnt_r;
      shift_nxt     = shift_r;
      tx_shift_nxt  = tx_shift_r;
      ack_phase_nxt = ack_phase_r;
      sda_nxt       = sda_r;
      rx_data_nxt   = rx_data_r;
      rx_valid_nxt  = 1'b0;
      tx_ready_nxt  = 1'b0;
      rw_nxt        = rw_r;
      busy_nxt      = busy_r;
      load_tx_s     = 1'b0;

      if (scl_fall_s) begin
         hold_cnt_nxt = HOLD_W'(HOLD_CYCLES);
      end else if (hold_cnt_r != {HOLD_W{1'b0}}) begin
         hold_cnt_nxt = hold_cnt_r - HOLD_W'(1);
      end else begin
         hold_cnt_nxt = hold_cnt_r;
      end

      // START/STOP take priority over any SCL edge seen in the same cycle.
      if (start_s) begin
         state_nxt     = ADDR;
         bit_cnt_nxt   = 4'd0;
         ack_phase_nxt = 1'b0;
         sda_nxt       = 1'b1;
         busy_nxt      = 1'b0;
         hold_cnt_nxt  = {HOLD_W{1'b0}};
      end else if (stop_s) begin
         state_nxt     = IDLE;
         bit_cnt_nxt   = 4'd0;
         ack_phase_nxt = 1'b0;
         sda_nxt       = 1'b1;
         busy_nxt      = 1'b0;
         hold_cnt_nxt  = {HOLD_W{1'b0}};
      end else begin
         case (state_r)
            IDLE, IGNORE: begin
               sda_nxt = 1'b1;
            end

            ADDR: begin
               if (scl_rise_s) begin
                  shift_nxt = byte_in_s[I2C_BYTE_W-2:0];
                  if (bit_cnt_r == 4'd7) begin
                     bit_cnt_nxt = 4'd8;
                     if (byte_in_s[I2C_BYTE_W-1:1] == slave_addr_i) begin
                        state_nxt     = ADDR_ACK;
                        rw_nxt        = byte_in_s[0];
                        ack_phase_nxt = 1'b0;
                     end else begin
                        state_nxt = IGNORE;
                     end
                  end else begin
                     bit_cnt_nxt = bit_cnt_r + 4'd1;
                  end
               end else begin
                  shift_nxt = shift_r;
               end
            end

            // ack_phase_r: 0 = ACK not yet driven, 1 = ACK on the line.
            ADDR_ACK, RX_ACK: begin
               if (scl_fall_s && ack_phase_r && (state_r == ADDR_ACK) && rw_r) begin
                  load_tx_s = 1'b1;
               end else begin
                  load_tx_s = 1'b0;
               end
               if (hold_done_s) begin
                  if (!ack_phase_r) begin
                     sda_nxt       = 1'b0;
                     ack_phase_nxt = 1'b1;
                     busy_nxt      = 1'b1;
                  end else begin
                     ack_phase_nxt = 1'b0;
                     bit_cnt_nxt   = 4'd0;
                     if ((state_r == ADDR_ACK) && rw_r) begin
                        // First read bit goes out in place of the ACK release.
                        sda_nxt      = tx_shift_r[I2C_BYTE_W-1];
                        tx_shift_nxt = {tx_shift_r[I2C_BYTE_W-2:0], 1'b0};
                        state_nxt    = TX_BYTE;
                     end else begin
                        sda_nxt   = 1'b1;
                        state_nxt = RX_BYTE;
                     end
                  end
               end else begin
                  sda_nxt = sda_r;
               end
            end

            RX_BYTE: begin
               if (scl_rise_s) begin
                  shift_nxt = byte_in_s[I2C_BYTE_W-2:0];
                  if (bit_cnt_r == 4'd7) begin
                     bit_cnt_nxt   = 4'd8;
                     rx_data_nxt   = byte_in_s;
                     rx_valid_nxt  = 1'b1;
                     state_nxt     = RX_ACK;
                     ack_phase_nxt = 1'b0;
                  end else begin
                     bit_cnt_nxt = bit_cnt_r + 4'd1;
                  end
               end else begin
                  shift_nxt = shift_r;
               end
            end

            // bit_cnt_r counts SCL rises, i.e. bits already taken by the master.
            TX_BYTE: begin
               if (scl_rise_s) begin
                  if (bit_cnt_r == 4'd8) begin
                     bit_cnt_nxt = 4'd8;
                  end else begin
                     bit_cnt_nxt = bit_cnt_r + 4'd1;
                  end
               end else begin
                  bit_cnt_nxt = bit_cnt_r;
               end
               if (hold_done_s) begin
                  if (bit_cnt_r == 4'd8) begin
                     sda_nxt       = 1'b1;
                     state_nxt     = TX_ACK;
                     ack_phase_nxt = 1'b0;
                  end else begin
                     sda_nxt      = tx_shift_r[I2C_BYTE_W-1];
                     tx_shift_nxt = {tx_shift_r[I2C_BYTE_W-2:0], 1'b0};
                  end
               end else begin
                  sda_nxt = sda_r;
               end
            end

            // ack_phase_r: 1 once the master has ACKed the byte just sent.
            TX_ACK: begin
               if (scl_rise_s && !ack_phase_r) begin
                  if (!sda_lvl_s) begin
                     ack_phase_nxt = 1'b1;
                  end else begin
                     state_nxt = IGNORE;
                     sda_nxt   = 1'b1;
                  end
               end else begin
                  ack_phase_nxt = ack_phase_r;
               end
               if (scl_fall_s && ack_phase_r) begin
                  load_tx_s = 1'b1;
               end else begin
                  load_tx_s = 1'b0;
               end
               if (hold_done_s && ack_phase_r) begin
                  sda_nxt       = tx_shift_r[I2C_BYTE_W-1];
                  tx_shift_nxt  = {tx_shift_r[I2C_BYTE_W-2:0], 1'b0};
                  bit_cnt_nxt   = 4'd0;
                  ack_phase_nxt = 1'b0;
                  state_nxt     = TX_BYTE;
               end else begin
                  bit_cnt_nxt = bit_cnt_r;
               end
            end

            default: begin
               state_nxt = IDLE;
               sda_nxt   = 1'b1;
            end
         endcase
      end

      // Byte fetch for a read happens on the SCL fall that ends the ACK bit.
      if (load_tx_s) begin
         if (tx_valid_i) begin
            tx_shift_nxt = tx_data_i;
            tx_ready_nxt = 1'b1;
         end else begin
            tx_shift_nxt = IDLE_BYTE;
            tx_ready_nxt = 1'b0;
         end
      end else begin
         tx_ready_nxt = 1'b0;
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_r     <= IDLE;
         bit_cnt_r   <= 4'd0;
         shift_r     <= {(I2C_BYTE_W-1){1'b0}};
         tx_shift_r  <= {I2C_BYTE_W{1'b0}};
         hold_cnt_r  <= {HOLD_W{1'b0}};
         ack_phase_r <= 1'b0;
         sda_r       <= 1'b1;
         rx_data_r   <= {I2C_BYTE_W{1'b0}};
         rx_valid_r  <= 1'b0;
         tx_ready_r  <= 1'b0;
         rw_r        <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt;
         bit_cnt_r   <= bit_cnt_nxt;
         shift_r     <= shift_nxt;
         tx_shift_r  <= tx_shift_nxt;
         hold_cnt_r  <= hold_cnt_nxt;
         ack_phase_r <= ack_phase_nxt;
         sda_r       <= sda_nxt;
         rx_data_r   <= rx_data_nxt;
         rx_valid_r  <= rx_valid_nxt;
         tx_ready_r  <= tx_ready_nxt;
         rw_r        <= rw_nxt;
         busy_r      <= busy_nxt;
      end
   end

   assign sda_o      = sda_r;
   assign rx_data_o  = rx_data_r;
   assign rx_valid_o = rx_valid_r;
   assign tx_ready_o = tx_ready_r;
   assign start_o    = start_s;
   assign stop_o     = stop_s;
   assign rw_o       = rw_r;
   assign busy_o     = busy_r;

endmodule

// File: tb/tb_i2c_responder.sv
// tb_i2c_responder
//   Directed bench: a bit-banged I2C master drives the responder through
//   write, read, address miss, repeated START, idle-byte read and a
//   mid-transfer reset.  Expected values are written out by hand.
`timescale 1ns/1ps
module tb_i2c_responder;

   localparam time Q = 200;   // quarter SCL period

   logic       clk_i;
   logic       rst_i;
   logic       scl_m;
   logic       sda_m;
   logic       sda_bus;
   logic       sda_o;
   logic [6:0] slave_addr_i;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic [7:0] tx_data_i;
   logic       tx_valid_i;
   logic       tx_ready_o;
   logic       start_o;
   logic       stop_o;
   logic       rw_o;
   logic       busy_o;

   int         checks   = 0;
   int         failures = 0;

   int         rx_cnt   = 0;
   int         txr_cnt  = 0;
   int         st_cnt   = 0;
   int         sp_cnt   = 0;
   int         lo_cnt   = 0;
   int         tx_idx   = 0;
   logic [7:0] rx_log [0:63];

   assign sda_bus   = sda_m & sda_o;
   assign tx_data_i = 8'h08 + tx_idx[7:0];

   i2c_responder dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .scl_i        (scl_m),
      .sda_i        (sda_bus),
      .sda_o        (sda_o),
      .slave_addr_i (slave_addr_i),
      .rx_data_o    (rx_data_o),
      .rx_valid_o   (rx_valid_o),
      .tx_data_i    (tx_data_i),
      .tx_valid_i   (tx_valid_i),
      .tx_ready_o   (tx_ready_o),
      .start_o      (start_o),
      .stop_o       (stop_o),
      .rw_o         (rw_o),
      .busy_o       (busy_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   // Byte source: advance to the next byte whenever the responder takes one.
   always @(posedge clk_i) begin
      if (tx_ready_o) tx_idx <= tx_idx + 1;
   end

   // Event monitor: log received bytes and count pulses / SDA pull-downs.
   always @(negedge clk_i) begin
      if (rx_valid_o) begin
         rx_log[rx_cnt[5:0]] <= rx_data_o;
         rx_cnt <= rx_cnt + 1;
      end
      if (tx_ready_o) txr_cnt <= txr_cnt + 1;
      if (start_o)    st_cnt  <= st_cnt + 1;
      if (stop_o)     sp_cnt  <= sp_cnt + 1;
      if (!sda_o)     lo_cnt  <= lo_cnt + 1;
   end

   initial begin
      #(4ms);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic settle();
      repeat (4) @(posedge clk_i);
      #1;
   endtask

   task automatic i2c_start();
      sda_m = 1'b1; #(Q);
      scl_m = 1'b1; #(Q);
      sda_m = 1'b0; #(Q);
      scl_m = 1'b0; #(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0; #(Q);
      scl_m = 1'b1; #(Q);
      sda_m = 1'b1; #(Q);
   endtask

   task automatic wr_bit(input logic b);
      sda_m = b;    #(Q);
      scl_m = 1'b1; #(2*Q);
      scl_m = 1'b0; #(Q);
   endtask

   task automatic rd_bit(output logic b);
      sda_m = 1'b1; #(Q);
      scl_m = 1'b1; #(Q);
      b = sda_bus;  #(Q);
      scl_m = 1'b0; #(Q);
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) wr_bit(d[i]);
      rd_bit(ack);
   endtask

   task automatic rd_byte(output logic [7:0] d, input logic nack);
      for (int i = 7; i >= 0; i--) rd_bit(d[i]);
      wr_bit(nack);
   endtask

   initial begin
      logic       ack;
      logic [7:0] rb;
      int         b_rx, b_tx, b_st, b_sp, b_lo;

      rst_i        = 1'b0;
      scl_m        = 1'b1;
      sda_m        = 1'b1;
      tx_valid_i   = 1'b1;
      slave_addr_i = 7'h12;
      repeat (5) @(negedge clk_i);

      // Reset state
      check_val("rst_sda",      {31'd0, sda_o},      32'd1);
      check_val("rst_busy",     {31'd0, busy_o},     32'd0);
      check_val("rst_rw",       {31'd0, rw_o},       32'd0);
      check_val("rst_rx_data",  {24'd0, rx_data_o},  32'd0);
      check_val("rst_rx_valid", {31'd0, rx_valid_o}, 32'd0);
      check_val("rst_tx_ready", {31'd0, tx_ready_o}, 32'd0);
      check_val("rst_start",    {31'd0, start_o},    32'd0);
      check_val("rst_stop",     {31'd0, stop_o},     32'd0);
      rst_i = 1'b1;
      repeat (10) @(negedge clk_i);

      // Write 0x24 then 0x00..0x07
      settle();
      b_rx = rx_cnt; b_st = st_cnt; b_sp = sp_cnt;
      i2c_start();
      wr_byte(8'h24, ack);
      check_val("w_addr_ack", {31'd0, ack},    32'd0);
      check_val("w_busy",     {31'd0, busy_o}, 32'd1);
      check_val("w_rw",       {31'd0, rw_o},   32'd0);
      for (int i = 0; i < 8; i++) begin
         wr_byte(i[7:0], ack);
         check_val($sformatf("w_ack%0d", i), {31'd0, ack}, 32'd0);
      end
      i2c_stop();
      settle();
      check_val("w_rx_count", rx_cnt - b_rx, 32'd8);
      for (int i = 0; i < 8; i++)
         check_val($sformatf("w_rx%0d", i), {24'd0, rx_log[b_rx + i]}, i);
      check_val("w_stop_count",  sp_cnt - b_sp, 32'd1);
      check_val("w_start_count", st_cnt - b_st, 32'd1);
      check_val("w_busy_after",  {31'd0, busy_o}, 32'd0);

      // Read 0x25, bytes 0x08..0x0F, NACK on the last
      b_tx = txr_cnt;
      i2c_start();
      wr_byte(8'h25, ack);
      check_val("r_addr_ack", {31'd0, ack},  32'd0);
      check_val("r_rw",       {31'd0, rw_o}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         rd_byte(rb, (i == 7));
         check_val($sformatf("r_data%0d", i), {24'd0, rb}, 32'h08 + i);
      end
      check_val("r_sda_after_nack", {31'd0, sda_o}, 32'd1);
      i2c_stop();
      settle();
      check_val("r_tx_ready_count", txr_cnt - b_tx, 32'd8);

      // Address miss: 0x13 write
      settle();
      b_rx = rx_cnt; b_lo = lo_cnt;
      i2c_start();
      wr_byte(8'h26, ack);
      check_val("miss_addr_nack", {31'd0, ack}, 32'd1);
      wr_byte(8'h5A, ack);
      check_val("miss_data_nack", {31'd0, ack}, 32'd1);
      i2c_stop();
      settle();
      check_val("miss_rx_count", rx_cnt - b_rx, 32'd0);
      check_val("miss_sda_low",  lo_cnt - b_lo, 32'd0);

      // Write 0x05, repeated START, read one byte
      b_rx = rx_cnt; b_st = st_cnt;
      i2c_start();
      wr_byte(8'h24, ack);
      check_val("rs_waddr_ack", {31'd0, ack},  32'd0);
      check_val("rs_rw0",       {31'd0, rw_o}, 32'd0);
      wr_byte(8'h05, ack);
      check_val("rs_wdata_ack", {31'd0, ack},  32'd0);
      i2c_start();
      wr_byte(8'h25, ack);
      check_val("rs_raddr_ack", {31'd0, ack},  32'd0);
      check_val("rs_rw1",       {31'd0, rw_o}, 32'd1);
      rd_byte(rb, 1'b1);
      check_val("rs_rdata", {24'd0, rb}, 32'h10);
      i2c_stop();
      settle();
      check_val("rs_start_count", st_cnt - b_st, 32'd2);
      check_val("rs_rx_count",    rx_cnt - b_rx, 32'd1);
      check_val("rs_rx_data",     {24'd0, rx_log[b_rx]}, 32'h05);

      // Read with no byte offered: idle byte, no tx_ready
      tx_valid_i = 1'b0;
      b_tx = txr_cnt;
      i2c_start();
      wr_byte(8'h25, ack);
      check_val("idle_addr_ack", {31'd0, ack}, 32'd0);
      rd_byte(rb, 1'b1);
      check_val("idle_rdata", {24'd0, rb}, 32'hFF);
      i2c_stop();
      settle();
      check_val("idle_tx_ready_count", txr_cnt - b_tx, 32'd0);
      tx_valid_i = 1'b1;

      // Reset during the 4th bit of a write data byte (0x5C, that bit is 1)
      b_rx = rx_cnt;
      i2c_start();
      wr_byte(8'h24, ack);
      check_val("rst_mid_addr_ack", {31'd0, ack}, 32'd0);
      wr_bit(1'b0);
      wr_bit(1'b1);
      wr_bit(1'b0);
      sda_m = 1'b1; #(Q);
      scl_m = 1'b1; #(Q);
      @(negedge clk_i) rst_i = 1'b0;
      @(negedge clk_i) rst_i = 1'b1;
      #(Q);
      scl_m = 1'b0; #(Q);
      check_val("rst_mid_sda", {31'd0, sda_o}, 32'd1);
      b_lo = lo_cnt;
      wr_bit(1'b1);
      wr_bit(1'b1);
      wr_bit(1'b0);
      wr_bit(1'b0);
      rd_bit(ack);
      check_val("rst_mid_nack", {31'd0, ack}, 32'd1);
      i2c_stop();
      settle();
      check_val("rst_mid_rx_count", rx_cnt - b_rx, 32'd0);
      check_val("rst_mid_sda_low",  lo_cnt - b_lo, 32'd0);
      check_val("rst_mid_busy",     {31'd0, busy_o}, 32'd0);

      // Next transfer after the reset works normally
      b_rx = rx_cnt;
      i2c_start();
      wr_byte(8'h24, ack);
      check_val("post_addr_ack", {31'd0, ack}, 32'd0);
      wr_byte(8'hA5, ack);
      check_val("post_data_ack", {31'd0, ack}, 32'd0);
      i2c_stop();
      settle();
      check_val("post_rx_count", rx_cnt - b_rx, 32'd1);
      check_val("post_rx_data",  {24'd0, rx_log[b_rx]}, 32'hA5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
